// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op/state encodings for the iterative mul/div unit
// Contents: op codes (also used by the ALU decoder), FSM states, iteration count.
package muldiv_pkg;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } muldiv_state_e;

  // Divide ops share the op[1] bit; keep the decode in one place.
  function automatic logic is_div_op(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_adder.sv
// rtl/muldiv_sequencer_adder.sv - shared 32-bit adder/subtractor (Adder32Bit)
// Ports: a, b (operands), subtract (1: a-b, 0: a+b), sum (modulo 2^32 result).
// No carry port; callers derive carry-out from the operand/sum MSBs.
module Adder32Bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        subtract,
  output logic [31:0] sum
);

  assign sum = a + (b ^ {32{subtract}}) + {31'h0, subtract};

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative unsigned MUL/MULHU/DIVU/REMU sequencer
// Ports: clk, reset_n (async active-low), start/op/operand_a/operand_b (request,
// sampled in IDLE or DONE), busy (iterating), done (1-cycle pulse), result (held).
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  muldiv_state_e state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  // Multiply: P = {hi, lo}. Divide reuses the same register as {R, Q}.
  logic [63:0]   p_q, p_d;
  // Multiplicand M for multiply, divisor D for divide.
  logic [31:0]   d_q, d_d;
  logic [31:0]   result_q, result_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          is_div;
  logic [31:0]   add_a, add_b, add_sum;
  logic          add_sub, cout, ge;
  logic [63:0]   step;

  assign is_div  = is_div_op(op_q);
  // Divide works on Rs[31:0] = {R[30:0], Q[31]}; multiply on the high half of P.
  assign add_a   = is_div ? p_q[62:31] : p_q[63:32];
  assign add_b   = (is_div || p_q[0]) ? d_q : 32'h0;
  assign add_sub = is_div;

  Adder32Bit u_adder (
    .a        (add_a),
    .b        (add_b),
    .subtract (add_sub),
    .sum      (add_sum)
  );

  // Carry-out reconstructed from MSBs; for subtract, carry=1 means no borrow.
  assign cout = add_sub
      ? ((add_a[31] & ~add_b[31]) | ((add_a[31] | ~add_b[31]) & ~add_sum[31]))
      : ((add_a[31] &  add_b[31]) | ((add_a[31] |  add_b[31]) & ~add_sum[31]));

  // Rs[32] is R[31]: a 33-bit partial remainder always covers the 32-bit divisor.
  assign ge = p_q[63] | cout;

  assign step = is_div ? {(ge ? add_sum : p_q[62:31]), p_q[30:0], ge}
                       : {cout, add_sum, p_q[31:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    p_d      = p_q;
    d_d      = d_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          op_d    = op;
          cnt_d   = 5'd0;
          p_d     = {32'h0, is_div_op(op) ? operand_a : operand_b};
          d_d     = is_div_op(op) ? operand_b : operand_a;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        p_d   = step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(MULDIV_ITERS - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          case (op_q)
            OP_MUL:   result_d = step[31:0];
            OP_MULHU: result_d = step[63:32];
            OP_DIVU:  result_d = step[31:0];
            default:  result_d = step[63:32];
          endcase
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 2'b00;
      p_q      <= 64'h0;
      d_q      <= 32'h0;
      result_q <= 32'h0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      p_q      <= p_d;
      d_q      <= d_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
